// File: rtl/if_id_queue.sv
// ----------------------------------------------------------------------------
// if_id_queue
//   IF/ID decoupling stage. A DEPTH-entry instruction FIFO sits in front of
//   the registered decode-side output (o_id_pc / o_id_inst / o_id_valid).
//   Fetch can keep running while decode is stalled, until the FIFO is full.
//   The output register keeps the classic IF/ID stall-vector semantics:
//     - flush           : FIFO emptied, outputs cleared
//     - !stall[DEC]     : load next instruction (FIFO head, or bypass if empty)
//     - stall[DEC] && !stall[DEC+1] : insert a bubble
//     - stall[DEC] &&  stall[DEC+1] : hold
//
// Ports
//   i_clk       clock, rising edge
//   i_rst_n     asynchronous reset, active low
//   i_stall     pipeline stall vector
//   i_flush     synchronous exception flush
//   i_if_valid  fetch offers i_if_pc / i_if_inst this cycle
//   i_if_pc     fetched PC
//   i_if_inst   fetched instruction
//   o_if_ready  queue can accept a fetch (count < DEPTH)
//   o_id_valid  o_id_pc / o_id_inst hold a real instruction
//   o_id_pc     PC to decode
//   o_id_inst   instruction to decode (0 = bubble / nop)
//   o_count     entries held in the FIFO (output register excluded)
// ----------------------------------------------------------------------------
module if_id_queue #(
   parameter int unsigned PC_W    = 32,
   parameter int unsigned INST_W  = 32,
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned STALL_W = 6,
   parameter int unsigned DEC_IDX = 1
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic [STALL_W-1:0]           i_stall,
   input  logic                         i_flush,
   input  logic                         i_if_valid,
   input  logic [PC_W-1:0]              i_if_pc,
   input  logic [INST_W-1:0]            i_if_inst,
   output logic                         o_if_ready,
   output logic                         o_id_valid,
   output logic [PC_W-1:0]              o_id_pc,
   output logic [INST_W-1:0]            o_id_inst,
   output logic [$clog2(DEPTH+1)-1:0]   o_count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH+1);

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic [PC_W-1:0]   r_mem_pc   [DEPTH];
   logic [INST_W-1:0] r_mem_inst [DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [CW-1:0]     r_count;

   logic              r_id_valid;
   logic [PC_W-1:0]   r_id_pc;
   logic [INST_W-1:0] r_id_inst;

   // ---------------------------------------------------------------------
   // Combinational control
   // ---------------------------------------------------------------------
   logic              w_ready;
   logic              w_accept;
   logic              w_empty;
   logic              w_load;
   logic              w_hold;
   logic              w_push;
   logic              w_pop;
   logic              w_id_valid_d;
   logic [PC_W-1:0]   w_id_pc_d;
   logic [INST_W-1:0] w_id_inst_d;
   logic [CW-1:0]     w_count_d;
   logic              w_unused_stall;

   // Only two stall bits matter here; the rest belong to other stages.
   assign w_unused_stall = ^i_stall;

   // Readiness depends on count alone: a full queue does not accept even
   // if a pop happens in the same cycle.
   assign w_ready  = (r_count < CW'(DEPTH));
   assign w_accept = i_if_valid && w_ready;
   assign w_empty  = (r_count == '0);
   assign w_load   = !i_stall[DEC_IDX];
   assign w_hold   = i_stall[DEC_IDX] && i_stall[DEC_IDX+1];

   always_comb begin
      w_push       = 1'b0;
      w_pop        = 1'b0;
      w_id_valid_d = r_id_valid;
      w_id_pc_d    = r_id_pc;
      w_id_inst_d  = r_id_inst;

      if (i_flush) begin
         // Accepted fetch is discarded along with the queue contents.
         w_id_valid_d = 1'b0;
         w_id_pc_d    = '0;
         w_id_inst_d  = '0;
      end else if (w_load) begin
         if (!w_empty) begin
            w_pop        = 1'b1;
            w_push       = w_accept;
            w_id_valid_d = 1'b1;
            w_id_pc_d    = r_mem_pc[r_rd_ptr];
            w_id_inst_d  = r_mem_inst[r_rd_ptr];
         end else if (w_accept) begin
            // Bypass only when the FIFO is empty, so ordering is preserved.
            w_id_valid_d = 1'b1;
            w_id_pc_d    = i_if_pc;
            w_id_inst_d  = i_if_inst;
         end else begin
            w_id_valid_d = 1'b0;
            w_id_pc_d    = '0;
            w_id_inst_d  = '0;
         end
      end else begin
         w_push = w_accept;
         if (!w_hold) begin
            // Decode stalled but the next stage is moving: emit a bubble.
            w_id_valid_d = 1'b0;
            w_id_pc_d    = '0;
            w_id_inst_d  = '0;
         end
      end
   end

   always_comb begin
      w_count_d = r_count;
      if (i_flush) begin
         w_count_d = '0;
      end else begin
         unique case ({w_push, w_pop})
            2'b10:   w_count_d = r_count + CW'(1);
            2'b01:   w_count_d = r_count - CW'(1);
            default: w_count_d = r_count;
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         // Pointers are exactly AW bits wide, so they wrap at DEPTH.
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= w_count_d;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_id_valid <= 1'b0;
         r_id_pc    <= '0;
         r_id_inst  <= '0;
      end else begin
         r_id_valid <= w_id_valid_d;
         r_id_pc    <= w_id_pc_d;
         r_id_inst  <= w_id_inst_d;
      end
   end

   // Storage is intentionally not reset; validity is tracked by ptrs/count.
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem_pc[r_wr_ptr]   <= i_if_pc;
         r_mem_inst[r_wr_ptr] <= i_if_inst;
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign o_if_ready = w_ready;
   assign o_id_valid = r_id_valid;
   assign o_id_pc    = r_id_pc;
   assign o_id_inst  = r_id_inst;
   assign o_count    = r_count;

endmodule

// File: tb/tb_if_id_queue.sv
// ----------------------------------------------------------------------------
// tb_if_id_queue
//   Directed self-checking bench for if_id_queue (DEPTH=4, STALL_W=6,
//   DEC_IDX=1). Inputs change 1 ns after a rising edge; outputs are checked
//   at that same point, i.e. after the edge's effect has settled.
// ----------------------------------------------------------------------------
module tb_if_id_queue;

   localparam int unsigned PC_W    = 32;
   localparam int unsigned INST_W  = 32;
   localparam int unsigned DEPTH   = 4;
   localparam int unsigned STALL_W = 6;
   localparam int unsigned DEC_IDX = 1;

   localparam logic [5:0] ST_RUN    = 6'b000000;
   localparam logic [5:0] ST_HOLD   = 6'b000110;
   localparam logic [5:0] ST_BUBBLE = 6'b000010;

   logic               clk;
   logic               rst_n;
   logic [STALL_W-1:0] stall;
   logic               flush;
   logic               if_valid;
   logic [PC_W-1:0]    if_pc;
   logic [INST_W-1:0]  if_inst;
   logic               if_ready;
   logic               id_valid;
   logic [PC_W-1:0]    id_pc;
   logic [INST_W-1:0]  id_inst;
   logic [2:0]         count;

   int n_checks;
   int n_fail;

   if_id_queue #(
      .PC_W    (PC_W),
      .INST_W  (INST_W),
      .DEPTH   (DEPTH),
      .STALL_W (STALL_W),
      .DEC_IDX (DEC_IDX)
   ) u_dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_stall    (stall),
      .i_flush    (flush),
      .i_if_valid (if_valid),
      .i_if_pc    (if_pc),
      .i_if_inst  (if_inst),
      .o_if_ready (if_ready),
      .o_id_valid (id_valid),
      .o_id_pc    (id_pc),
      .o_id_inst  (id_inst),
      .o_count    (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction word derived from the PC so every entry is distinguishable.
   function automatic logic [31:0] inst_of(input logic [31:0] pc);
      return {16'hC0DE, pc[15:0]};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [5:0] st, input logic fl, input logic v,
                        input logic [31:0] pc);
      stall    = st;
      flush    = fl;
      if_valid = v;
      if_pc    = pc;
      if_inst  = inst_of(pc);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input logic v, input logic [31:0] pc,
                            input logic [2:0] cnt);
      check({tag, ".valid"}, 64'(id_valid), 64'(v));
      check({tag, ".pc"}, 64'(id_pc), 64'(pc));
      check({tag, ".inst"}, 64'(id_inst), v ? 64'(inst_of(pc)) : 64'd0);
      check({tag, ".count"}, 64'(count), 64'(cnt));
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      drive(ST_RUN, 1'b0, 1'b0, 32'h0);
      #1;
      // T1a: plain reset state
      check_out("rst0", 1'b0, 32'h0, 3'd0);
      check("rst0.ready", 64'(if_ready), 64'd1);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // T2: bypass stream, latency 1, count stays 0
      for (int i = 0; i < 3; i++) begin
         drive(ST_RUN, 1'b0, 1'b1, 32'h100 + 32'(4 * i));
         tick();
         check_out($sformatf("byp%0d", i), 1'b1, 32'h100 + 32'(4 * i), 3'd0);
      end

      // T3: fill under hold; output keeps 0x108
      for (int k = 0; k < 5; k++) begin
         drive(ST_HOLD, 1'b0, 1'b1, 32'h200 + 32'(4 * k));
         if (k == 4) check("fill.ready_full", 64'(if_ready), 64'd0);
         tick();
         check_out($sformatf("fill%0d", k), 1'b1, 32'h108, (k < 4) ? 3'(k + 1) : 3'd4);
      end
      // release: drain four entries in order, fifth fetch never entered
      for (int k = 0; k < 4; k++) begin
         drive(ST_RUN, 1'b0, 1'b0, 32'h0);
         tick();
         check_out($sformatf("drain%0d", k), 1'b1, 32'h200 + 32'(4 * k), 3'(3 - k));
      end
      tick();
      check_out("drain_empty", 1'b0, 32'h0, 3'd0);

      // T4: bubble with two entries queued, one more accepted
      drive(ST_HOLD, 1'b0, 1'b1, 32'h300);
      tick();
      drive(ST_HOLD, 1'b0, 1'b1, 32'h304);
      tick();
      check_out("pre_bub", 1'b0, 32'h0, 3'd2);
      drive(ST_BUBBLE, 1'b0, 1'b1, 32'h308);
      tick();
      check_out("bubble", 1'b0, 32'h0, 3'd3);
      drive(ST_RUN, 1'b0, 1'b0, 32'h0);
      tick();
      check_out("post_bub", 1'b1, 32'h300, 3'd2);

      // T5: flush with count=3 and a concurrent fetch
      drive(ST_HOLD, 1'b0, 1'b1, 32'h30C);
      tick();
      check_out("pre_flush", 1'b1, 32'h300, 3'd3);
      drive(ST_RUN, 1'b1, 1'b1, 32'h400);
      tick();
      check_out("flush", 1'b0, 32'h0, 3'd0);
      check("flush.ready", 64'(if_ready), 64'd1);
      drive(ST_RUN, 1'b0, 1'b1, 32'h404);
      tick();
      check_out("post_flush", 1'b1, 32'h404, 3'd0);
      drive(ST_RUN, 1'b0, 1'b0, 32'h0);
      tick();
      check_out("flush_gone", 1'b0, 32'h0, 3'd0);

      // T6: count=2 then 10 cycles of push+pop; pointers wrap
      drive(ST_HOLD, 1'b0, 1'b1, 32'h500);
      tick();
      drive(ST_HOLD, 1'b0, 1'b1, 32'h504);
      tick();
      check("wrap.start_count", 64'(count), 64'd2);
      for (int i = 0; i < 10; i++) begin
         drive(ST_RUN, 1'b0, 1'b1, 32'h508 + 32'(4 * i));
         tick();
         check_out($sformatf("wrap%0d", i), 1'b1, 32'h500 + 32'(4 * i), 3'd2);
      end
      for (int i = 0; i < 2; i++) begin
         drive(ST_RUN, 1'b0, 1'b0, 32'h0);
         tick();
         check_out($sformatf("wrap_drain%0d", i), 1'b1, 32'h528 + 32'(4 * i), 3'(1 - i));
      end
      tick();
      check_out("wrap_empty", 1'b0, 32'h0, 3'd0);

      // T1b: asynchronous reset with three entries queued and a valid output
      drive(ST_RUN, 1'b0, 1'b1, 32'h600);
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(ST_HOLD, 1'b0, 1'b1, 32'h604 + 32'(4 * i));
         tick();
      end
      check_out("pre_rst", 1'b1, 32'h600, 3'd3);
      #2;
      rst_n = 1'b0;
      #1;
      check_out("async_rst", 1'b0, 32'h0, 3'd0);
      check("async_rst.ready", 64'(if_ready), 64'd1);
      drive(ST_RUN, 1'b0, 1'b0, 32'h0);
      tick();
      rst_n = 1'b1;
      tick();
      check_out("after_rst", 1'b0, 32'h0, 3'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Safety net in case the clock or a task stalls.
   initial begin
      #100000;
      $display("FAIL timeout: got no end of test, expected completion");
      $fatal(1);
   end

endmodule
